// File: rtl/data_mem_responder.sv
// Responder side of the processor memory interface: one byte-addressed load/store
// at a time against a word RAM, with lane extraction and read-modify-write for sub-word stores.
module data_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_op,
  input  logic [31:0] mem_data_in,
  output logic        resp_valid,
  output logic [31:0] mem_data_out,
  output logic        mem_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0] OP_LB  = 8'd1, OP_LH  = 8'd2, OP_LW = 8'd3, OP_LBU = 8'd4,
                         OP_LHU = 8'd5, OP_SB  = 8'd6, OP_SH = 8'd7, OP_SW  = 8'd8;

  typedef enum logic [2:0] {IDLE, READ, MODIFY, WRITE, RESP} state_t;

  state_t state, state_n;

  logic [31:0]   ram [DEPTH];
  logic [31:0]   rd_q, word_q, data_q, load_val;
  logic [7:0]    op_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          accept, req_err, is_h, is_w, is_load_q;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;

  always_comb begin
    is_h    = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    is_w    = (mem_op == OP_LW) || (mem_op == OP_SW);
    req_err = (mem_op == 8'd0) || (mem_op > OP_SW)
            || (is_h && mem_addr[0])
            || (is_w && (mem_addr[1:0] != 2'b00))
            || ({2'b00, mem_addr[31:2]} >= 32'(DEPTH));
  end

  assign is_load_q = (op_q >= OP_LB) && (op_q <= OP_LHU);

  always_comb begin
    byte_v   = rd_q[{lane_q, 3'b000} +: 8];
    half_v   = rd_q[{lane_q[1], 4'b0000} +: 16];
    load_val = rd_q;
    case (op_q)
      OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
      OP_LH:   load_val = {{16{half_v[15]}}, half_v};
      OP_LBU:  load_val = {24'd0, byte_v};
      OP_LHU:  load_val = {16'd0, half_v};
      default: load_val = rd_q;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = req_err ? RESP : READ;
      READ:    if (is_load_q)         state_n = RESP;
               else if (op_q == OP_SW) state_n = WRITE;
               else                    state_n = MODIFY;
      MODIFY:  state_n = WRITE;
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_data_out <= 32'd0;
      mem_err      <= 1'b0;
    end else begin
      if (accept) begin
        mem_err <= req_err;
        if (req_err) mem_data_out <= 32'd0;
      end
      if (state == READ && is_load_q) mem_data_out <= load_val;
    end
  end

  // Request capture and merge buffer carry no reset; they are only consumed downstream of an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= mem_op;
      lane_q <= mem_addr[1:0];
      idx_q  <= mem_addr[AW+1:2];
      data_q <= mem_data_in;
    end
    case (state)
      READ:    word_q <= (op_q == OP_SW) ? data_q : rd_q;
      MODIFY:  if (op_q == OP_SB) word_q[{lane_q, 3'b000} +: 8]     <= data_q[7:0];
               else               word_q[{lane_q[1], 4'b0000} +: 16] <= data_q[15:0];
      default: ;
    endcase
  end

  // Write gated by rst so a store aborted on a reset edge never reaches memory.
  always_ff @(posedge clk) begin
    if (accept && !req_err) rd_q <= ram[mem_addr[AW+1:2]];
    if (rst && state == WRITE) ram[idx_q] <= word_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder against an array-based memory model.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] mem_addr = '0;
  logic [7:0]  mem_op = '0;
  logic [31:0] mem_data_in = '0;
  logic        resp_valid;
  logic [31:0] mem_data_out;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_out = 32'd0;

  data_mem_responder #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_addr(mem_addr), .mem_op(mem_op), .mem_data_in(mem_data_in),
    .resp_valid(resp_valid), .mem_data_out(mem_data_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: expected outcome of one request from the access rules, updating the model on stores.
  task automatic model(input logic [31:0] a, input logic [7:0] op, input logic [31:0] d,
                       output logic err, output logic [31:0] data, output int lat);
    int unsigned widx, lane, b, h;
    logic [31:0] w;
    widx = a / 4;
    lane = a % 4;
    err  = (op == 0) || (op > 8)
        || ((op == 2 || op == 5 || op == 7) && (a % 2 != 0))
        || ((op == 3 || op == 8) && (a % 4 != 0))
        || (widx >= DEPTH);
    data = last_out;
    lat  = 1;
    if (err) begin
      data = 32'd0;
    end else begin
      w = mem_m[widx];
      b = (w >> (8 * lane)) & 32'hFF;
      h = (w >> (8 * lane)) & 32'hFFFF;
      case (op)
        1: begin data = (b >= 128) ? (b | 32'hFFFFFF00) : b; lat = 2; end
        2: begin data = (h >= 32768) ? (h | 32'hFFFF0000) : h; lat = 2; end
        3: begin data = w; lat = 2; end
        4: begin data = b; lat = 2; end
        5: begin data = h; lat = 2; end
        6: begin mem_m[widx] = (w & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane)); lat = 4; end
        7: begin mem_m[widx] = (w & ~(32'hFFFF << (8 * lane))) | ((d & 32'hFFFF) << (8 * lane)); lat = 4; end
        default: begin mem_m[widx] = d; lat = 3; end
      endcase
    end
    last_out = data;
  endtask

  task automatic do_req(input string tag, input logic [31:0] a, input logic [7:0] op,
                        input logic [31:0] d);
    logic        e_err;
    logic [31:0] e_data;
    int          e_lat, lat, w;
    model(a, op, d, e_err, e_data, e_lat);
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    mem_addr = a; mem_op = op; mem_data_in = d; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    mem_addr = $urandom; mem_op = 8'($urandom); mem_data_in = $urandom;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 8) begin
      chk({tag, ".busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
    chk({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
    chk({tag, ".err"}, 32'(mem_err), 32'(e_err));
    chk({tag, ".data"}, mem_data_out, e_data);
  endtask

  initial begin
    int accepts, resps;
    logic [31:0] a, d, exp_w;
    logic [7:0]  op;
    logic        e_err;
    logic [31:0] e_data;
    int          e_lat;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ready", 32'(req_ready), 32'd1);
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.data", mem_data_out, 32'd0);
    chk("reset.err", 32'(mem_err), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) do_req("init", 32'(4 * i), 8'd8, $urandom);
    do_req("init_w4", 32'h10, 8'd8, 32'h8001FF7F);

    do_req("lw10", 32'h10, 8'd3, 32'd0);
    do_req("lb10", 32'h10, 8'd1, 32'd0);
    do_req("lb11", 32'h11, 8'd1, 32'd0);
    do_req("lbu11", 32'h11, 8'd4, 32'd0);
    do_req("lh12", 32'h12, 8'd2, 32'd0);
    chk("lh12.abs", mem_data_out, 32'hFFFF8001);
    do_req("sh12", 32'h12, 8'd7, 32'h1234BEEF);
    do_req("lw10b", 32'h10, 8'd3, 32'd0);
    chk("lw10b.abs", mem_data_out, 32'hBEEFFF7F);
    do_req("lhu12", 32'h12, 8'd5, 32'd0);

    do_req("err_lh13", 32'h13, 8'd2, 32'd0);
    do_req("err_lw12", 32'h12, 8'd3, 32'd0);
    do_req("err_op9", 32'h10, 8'd9, 32'd0);
    do_req("err_op0", 32'h10, 8'd0, 32'd0);
    do_req("err_oor", 32'(4 * DEPTH), 8'd3, 32'd0);
    do_req("err_sw_oor", 32'(4 * DEPTH), 8'd8, 32'hCAFEF00D);
    do_req("err_sh11", 32'h11, 8'd7, 32'hFFFF);
    do_req("lw10c", 32'h10, 8'd3, 32'd0);
    do_req("sb13", 32'h13, 8'd6, 32'h000000A5);
    do_req("lw10d", 32'h10, 8'd3, 32'd0);
    do_req("last_word", 32'(4 * DEPTH - 4), 8'd8, 32'h0BADCAFE);
    do_req("last_word_rd", 32'(4 * DEPTH - 1), 8'd1, 32'd0);

    // Store aborted by reset while in WRITE must leave memory untouched.
    exp_w = mem_m[8];
    @(negedge clk);
    chk("abort.ready", 32'(req_ready), 32'd1);
    mem_addr = 32'h20; mem_op = 8'd8; mem_data_in = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort.pre_resp", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("abort.ready_after", 32'(req_ready), 32'd1);
    chk("abort.data_after", mem_data_out, 32'd0);
    chk("abort.err_after", 32'(mem_err), 32'd0);
    resps = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) resps++;
    end
    chk("abort.no_resp", 32'(resps), 32'd0);
    last_out = 32'd0;
    do_req("abort.lw20", 32'h20, 8'd3, 32'd0);
    chk("abort.prior", mem_data_out, exp_w);

    // Continuous req_valid: one accept per response, ready low while busy.
    accepts = 0; resps = 0;
    @(negedge clk);
    mem_addr = 32'h10; mem_op = 8'd3; mem_data_in = 32'd0; req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        chk("stream.data", mem_data_out, mem_m[4]);
        chk("stream.ready_in_resp", 32'(req_ready), 32'd0);
      end
      if (i < 29) @(negedge clk);
    end
    req_valid = 1'b0;
    chk("stream.accepts", 32'(accepts), 32'd10);
    chk("stream.resps", 32'(resps), 32'd10);
    model(32'h10, 8'd3, 32'd0, e_err, e_data, e_lat);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(4 * DEPTH) + $urandom_range(0, 15);
        1:       a = $urandom;
        default: a = $urandom_range(0, 63);
      endcase
      op = 8'($urandom_range(0, 10));
      d  = $urandom;
      do_req("rand", a, op, d);
    end
    for (int i = 0; i < 16; i++) do_req("final", 32'(4 * i), 8'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
